// File: rtl/uart_dump.sv
// Reads DUMP_WORDS 32-bit words over a simple read port, starting at DUMP_BASE.
// Each word goes out on an 8N1 UART line as four frames, least significant byte first.
module uart_dump #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter logic [31:0] DUMP_BASE  = 32'h0000_0000,
  parameter int unsigned DUMP_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump_start_i,
  output logic        rib_rd_req_o,
  output logic [31:0] mem_rd_addr_o,
  input  logic [31:0] mem_rd_data_i,
  output logic        uart_tx,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  dbg_state_o
);

  localparam int unsigned DIV       = CLK_FREQ / BAUD;
  localparam int unsigned CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [15:0]   WORD_LAST = 16'(DUMP_WORDS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_REQ   = 3'd1;
  localparam logic [2:0] S_RD_CAP   = 3'd2;
  localparam logic [2:0] S_TX_START = 3'd3;
  localparam logic [2:0] S_TX_DATA  = 3'd4;
  localparam logic [2:0] S_TX_STOP  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [15:0]   word_q, word_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   shift_q, shift_d;
  logic          done_q, done_d;
  logic          bit_end;
  logic          in_tx;

  assign bit_end = (baud_q == BAUD_LAST);
  assign in_tx   = (state_q == S_TX_START) || (state_q == S_TX_DATA) || (state_q == S_TX_STOP);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    // The bit timer restarts whenever a bit period ends; every state change happens on such an end.
    baud_d  = '0;
    if (in_tx && !bit_end) begin
      baud_d = baud_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (dump_start_i) begin
          state_d = S_RD_REQ;
          word_d  = '0;
          addr_d  = DUMP_BASE;
        end
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: begin
        shift_d = mem_rd_data_i;
        byte_d  = '0;
        state_d = S_TX_START;
      end
      S_TX_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_TX_DATA;
        end
      end
      S_TX_DATA: begin
        if (bit_end) begin
          // Shifting right leaves the next byte in shift_q[7:0] after eight bits.
          shift_d = {1'b0, shift_q[31:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = S_TX_STOP;
          end
        end
      end
      S_TX_STOP: begin
        if (bit_end) begin
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 1'b1;
            state_d = S_TX_START;
          end else if (word_q != WORD_LAST) begin
            word_d  = word_q + 1'b1;
            addr_d  = addr_q + 32'd4;
            state_d = S_RD_REQ;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      S_TX_START: uart_tx = 1'b0;
      S_TX_DATA:  uart_tx = shift_q[0];
      default:    uart_tx = 1'b1;
    endcase
  end

  assign rib_rd_req_o  = (state_q == S_RD_REQ) || (state_q == S_RD_CAP);
  assign mem_rd_addr_o = rib_rd_req_o ? addr_q : 32'h0;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_uart_dump.sv
// Bench for uart_dump: table-driven and random dumps decoded by a UART receiver model,
// plus start-noise, mid-frame reset and start-on-done sequences.
module tb_uart_dump;

  localparam int CLK_FREQ = 40;
  localparam int BAUD     = 10;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int WORDS    = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam int DUMP_CYC = WORDS * (2 + 40 * DIV);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dump_start_i = 1'b0;
  logic        rib_rd_req_o;
  logic [31:0] mem_rd_addr_o;
  logic [31:0] mem_rd_data_i;
  logic        uart_tx;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  dbg_state;

  uart_dump #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DUMP_BASE(BASE), .DUMP_WORDS(WORDS)
  ) dut (
    .clk(clk), .rst(rst), .dump_start_i(dump_start_i),
    .rib_rd_req_o(rib_rd_req_o), .mem_rd_addr_o(mem_rd_addr_o),
    .mem_rd_data_i(mem_rd_data_i), .uart_tx(uart_tx),
    .busy_o(busy_o), .done_o(done_o), .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // memory model: word w lives at BASE + 4*w (wrapping through zero)
  logic [31:0] mem_w [WORDS];
  logic [31:0] addr_off;
  assign addr_off      = mem_rd_addr_o - BASE;
  assign mem_rd_data_i = mem_w[addr_off[3:2]];

  // scoreboard
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr_q[$];
  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  bit line_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // UART receiver model, samples mid-bit on falling clock edges
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
      rx_cnt    = 0;
    end else if (!rx_active) begin
      if (uart_tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == DIV / 2) begin
        check("rx_start_mid", 32'(uart_tx), 32'd0);
      end else if (rx_cnt < DIV / 2 + 9 * DIV && (rx_cnt - DIV / 2) % DIV == 0) begin
        rx_byte = {uart_tx, rx_byte[7:1]};
      end else if (rx_cnt == DIV / 2 + 9 * DIV) begin
        check("rx_stop_bit", 32'(uart_tx), 32'd1);
        check("rx_frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        rx_active = 1'b0;
      end
    end
  end

  // read-port and done monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (rib_rd_req_o) begin
        check("rd_expected", 32'(exp_addr_q.size() > 0), 32'd1);
        if (exp_addr_q.size() > 0) check("rd_addr", mem_rd_addr_o, exp_addr_q.pop_front());
        if (uart_tx !== 1'b1) line_bad = 1'b1;
      end else if (mem_rd_addr_o !== 32'h0) begin
        line_bad = 1'b1;
      end
    end
    if (done_o) done_cnt++;
  end

  // reference model: load memory, queue the expected byte stream (first n_bytes only)
  task automatic load_random(input int n_bytes);
    for (int w = 0; w < WORDS; w++) begin
      mem_w[w] = $urandom;
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k < n_bytes) exp_q.push_back(8'((mem_w[w] >> (8 * k)) & 32'hFF));
      end
    end
  endtask

  task automatic push_addrs(input int n_words);
    for (int w = 0; w < n_words; w++) begin
      exp_addr_q.push_back(BASE + 32'(4 * w));
      exp_addr_q.push_back(BASE + 32'(4 * w));
    end
  endtask

  // driver: call at #1 after a rising edge; returns in the done_o cycle
  task automatic run_dump(input bit noise);
    int cyc;
    bit seen;
    bit busy_drop;
    push_addrs(WORDS);
    dump_start_i = 1'b1;
    @(posedge clk); #1;
    dump_start_i = 1'b0;
    check("busy_after_start", 32'(busy_o), 32'd1);
    check("rd_req_after_start", 32'(rib_rd_req_o), 32'd1);
    check("addr_after_start", mem_rd_addr_o, BASE);
    cyc = 0; seen = 1'b0; busy_drop = 1'b0;
    while (!seen && cyc < DUMP_CYC + 200) begin
      dump_start_i = noise && (cyc == DUMP_CYC - 1 || $urandom_range(0, 39) == 0);
      @(posedge clk); #1;
      cyc++;
      if (done_o) begin
        seen = 1'b1;
        dump_start_i = 1'b0;
      end else if (!busy_o) begin
        busy_drop = 1'b1;
      end
    end
    dump_start_i = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("dump_cycles", 32'(cyc), 32'(DUMP_CYC));
    check("busy_continuous", 32'(busy_drop), 32'd0);
    check("busy_at_done", 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  vec_t tbl [WORDS];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h1234_5678, 8'h78, 8'h56, 8'h34, 8'h12};
    tbl[1] = '{32'hA5A5_A5A5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    tbl[2] = '{32'h0000_00FF, 8'hFF, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int w = 0; w < WORDS; w++) mem_w[w] = 32'h0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_rd_req", 32'(rib_rd_req_o), 32'd0);
    check("rst_addr", mem_rd_addr_o, 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_uart_tx", 32'(uart_tx), 32'd1);
    check("idle_busy", 32'(busy_o), 32'd0);

    // table-driven dump: known words, hand-written byte expectations
    for (int i = 0; i < WORDS; i++) begin
      mem_w[i] = tbl[i].word;
      exp_q.push_back(tbl[i].b0);
      exp_q.push_back(tbl[i].b1);
      exp_q.push_back(tbl[i].b2);
      exp_q.push_back(tbl[i].b3);
    end
    run_dump(1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("table_bytes_drained", 32'(exp_q.size()), 32'd0);

    // random words with start pulses sprinkled through the dump
    load_random(4 * WORDS);
    run_dump(1'b1);
    repeat (6) @(posedge clk);
    #1;

    // reset during the data bits of byte 2 of the first word
    load_random(2);
    push_addrs(1);
    dump_start_i = 1'b1;
    @(posedge clk); #1;
    dump_start_i = 1'b0;
    repeat (2 + 80 + DIV + 10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_uart_tx", 32'(uart_tx), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_rd_req", 32'(rib_rd_req_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_bytes_drained", 32'(exp_q.size()), 32'd0);
    check("abort_addrs_drained", 32'(exp_addr_q.size()), 32'd0);
    check("abort_done_count", 32'(done_cnt), 32'd2);
    // start on the very first edge after reset release
    rst = 1'b0;
    load_random(4 * WORDS);
    run_dump(1'b0);

    // back-to-back: start coincident with done_o
    load_random(4 * WORDS);
    run_dump(1'b0);
    load_random(4 * WORDS);
    run_dump(1'b0);

    repeat (20) @(posedge clk);
    #1;
    check("final_bytes_drained", 32'(exp_q.size()), 32'd0);
    check("final_addrs_drained", 32'(exp_addr_q.size()), 32'd0);
    check("final_done_count", 32'(done_cnt), 32'd5);
    check("line_idle_rules", 32'(line_bad), 32'd0);
    check("final_busy", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_dump.md
UART_DUMP -- requirements
Module: uart_dump

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART line rate; bit period DIV = CLK_FREQ/BAUD (integer divide, 434 at defaults).
REQ-003 Parameter DUMP_BASE, default 32'h0000_0000, byte address of the first word dumped.
REQ-004 Parameter DUMP_WORDS, default 256, number of 32-bit words per dump, range 1..65535.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 dump_start_i  input  1  single-cycle start pulse.
REQ-008 rib_rd_req_o  output  1  rib master read request.
REQ-009 mem_rd_addr_o  output  32  rib read byte address.
REQ-010 mem_rd_data_i  input  32  rib read data.
REQ-011 uart_tx  output  1  serial output, 8N1, idle high.
REQ-012 busy_o  output  1  high from start acceptance until dump completion.
REQ-013 done_o  output  1  one-cycle pulse on dump completion.

Function
REQ-014 FSM states SHALL be IDLE, RD_REQ, RD_CAP, TX_START, TX_DATA, TX_STOP.
REQ-015 IDLE: dump_start_i=1 -> word index 0, address DUMP_BASE, busy_o=1, go RD_REQ next cycle.
REQ-016 RD_REQ (1 cycle) and RD_CAP (1 cycle): rib_rd_req_o=1, mem_rd_addr_o=current address; at end of RD_CAP, mem_rd_data_i captured into 32-bit shift word, byte index=0, go TX_START.
REQ-017 rib_rd_req_o SHALL be 0 and mem_rd_addr_o SHALL be 0 in all other states.
REQ-018 Baud counter counts 0..DIV-1, cleared on every state entry; each TX state lasts exactly DIV cycles per bit.
REQ-019 TX_START: uart_tx=0 for DIV cycles; TX_DATA: 8 bits, LSB first, DIV cycles each; TX_STOP: uart_tx=1 for DIV cycles.
REQ-020 Byte order per word little-endian: bits[7:0] first, bits[31:24] last.
REQ-021 End of TX_STOP with byte index<3: byte index+1, go TX_START (no idle gap).
REQ-022 End of TX_STOP with byte index=3 and word index<DUMP_WORDS-1: word index+1, address+4, go RD_REQ.
REQ-023 End of TX_STOP with byte index=3 and word index=DUMP_WORDS-1: go IDLE, busy_o=0 and done_o=1 in the following cycle.
REQ-024 Address increment SHALL be modulo 2^32 (wraps 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 dump_start_i while busy_o=1 SHALL be ignored, including in the done_o cycle's preceding TX_STOP cycle.
REQ-026 dump_start_i coincident with done_o SHALL be accepted (IDLE entered that cycle).
REQ-027 uart_tx SHALL be 1 in IDLE, RD_REQ, RD_CAP.
REQ-028 Per-word duration: 2 + 40*DIV cycles; full dump: DUMP_WORDS*(2+40*DIV) cycles from start acceptance to done_o.

Reset
REQ-029 rst=1 asynchronously forces: state IDLE, uart_tx=1, rib_rd_req_o=0, mem_rd_addr_o=0, busy_o=0, done_o=0, all counters and shift word cleared.
REQ-030 Reset mid-frame SHALL abort the dump immediately with no done_o; a new dump restarts from DUMP_BASE.
REQ-031 After rst release, first accepted dump_start_i is the first clock edge with rst=0.

Verification
REQ-032 DUMP_WORDS=1, memory[0]=32'h1234_5678, pulse start -> rib_rd_req_o high 2 cycles at addr 0; bytes 0x78,0x56,0x34,0x12 on uart_tx, each bit 434 cycles; done_o at cycle 2+17360 after acceptance.
REQ-033 DUMP_WORDS=3, words 0xA5A5A5A5,0x0000_00FF,0xFFFF_FFFF -> addresses 0,4,8 read in order; 12 frames decoded correctly; exactly one done_o.
REQ-034 DUMP_BASE=32'hFFFF_FFFC, DUMP_WORDS=2 -> second read address 32'h0000_0000.
REQ-035 Start pulses mid-dump at random cycles -> ignored, dump length and content unchanged, busy_o stays high continuously.
REQ-036 rst asserted during TX_DATA of byte 2 -> uart_tx=1 same cycle, busy_o=0, no done_o; subsequent start dumps from DUMP_BASE fully.
REQ-037 Start on done_o cycle -> second dump begins with rib_rd_req_o next cycle at DUMP_BASE, no missed or extra frame.
